// File: rtl/serial_adder.sv
// serial_adder: digit-serial add/subtract, LSB digit first, with valid/ready handshakes on both sides
module serial_adder #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);
    localparam int N = WIDTH / DIGIT;
    localparam int CW = N > 1 ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_r, b_r, s_nx;
    logic             c_r, c_msb, last;
    logic [CW-1:0]    cnt;
    logic [DIGIT:0]   dsum;

    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign last      = cnt == LAST;
    assign dsum      = {1'b0, a_r[DIGIT-1:0]} + {1'b0, b_r[DIGIT-1:0]} + {{DIGIT{1'b0}}, c_r};
    // carry into the top bit of the digit, recovered from the sum bit
    assign c_msb     = dsum[DIGIT-1] ^ a_r[DIGIT-1] ^ b_r[DIGIT-1];

    always_comb begin
        s_nx = s;
        for (int i = 0; i < N; i++)
            if (cnt == CW'(i)) s_nx[i*DIGIT +: DIGIT] = dsum[DIGIT-1:0];
    end

    always_comb begin
        state_nx = state == IDLE ? (in_valid ? RUN : IDLE) :
                   state == RUN  ? (last ? DONE : RUN) :
                   (out_ready ? IDLE : DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r  <= '0;
            b_r  <= '0;
            c_r  <= 1'b0;
            cnt  <= '0;
            s    <= '0;
            cout <= 1'b0;
            ovf  <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            a_r <= a;
            b_r <= sub ? ~b : b;
            c_r <= sub ^ cin;
            cnt <= '0;
        end else if (state == RUN) begin
            a_r <= a_r >> DIGIT;
            b_r <= b_r >> DIGIT;
            c_r <= dsum[DIGIT];
            cnt <= cnt + 1'b1;
            s   <= s_nx;
            if (last) begin
                cout <= dsum[DIGIT];
                ovf  <= c_msb ^ dsum[DIGIT];
            end
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed and random checks of serial_adder at DIGIT=1, 4 and 16 against an arithmetic model
module tb_serial_adder;
    logic        clk, rst_n;
    logic [15:0] a, b;
    logic        cin, sub;
    logic [2:0]  iv, ordy, ir, ov, co, of;
    logic [15:0] sw [3];
    int          chk, err;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        serial_adder #(.WIDTH(16), .DIGIT(g == 0 ? 1 : g == 1 ? 4 : 16)) u_dut (
            .clk(clk), .rst_n(rst_n),
            .in_valid(iv[g]), .in_ready(ir[g]),
            .a(a), .b(b), .cin(cin), .sub(sub),
            .out_valid(ov[g]), .out_ready(ordy[g]),
            .s(sw[g]), .cout(co[g]), .ovf(of[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk++;
        assert (obs === exp) else begin
            err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {ovf, cout, s} from signed/unsigned integer arithmetic
    function automatic logic [17:0] model(input logic [15:0] av, input logic [15:0] bv, input logic ci, input logic sb);
        int ua, ub, c, r, sa, sbv, sr;
        logic [15:0] rs;
        logic rc, ro;
        ua = int'(av); ub = int'(bv); c = int'(ci);
        sa = int'($signed(av)); sbv = int'($signed(bv));
        r  = sb ? ua - ub - c : ua + ub + c;
        sr = sb ? sa - sbv - c : sa + sbv + c;
        rs = r[15:0];
        rc = sb ? (r >= 0) : (r > 65535);
        ro = (sr > 32767) || (sr < -32768);
        return {ro, rc, rs};
    endfunction

    task automatic run_op(input int k, input logic [15:0] av, input logic [15:0] bv,
                          input logic ci, input logic sb, input int stall);
        int n, t;
        logic [17:0] m;
        n = k == 0 ? 16 : k == 1 ? 4 : 1;
        m = model(av, bv, ci, sb);
        a = av; b = bv; cin = ci; sub = sb;
        ordy[k] = stall == 0;
        iv[k] = 1'b1;
        t = 0;
        while (!ir[k] && t < 50) begin @(posedge clk); #1; t++; end
        check("accept_wait", t < 50, 1);
        @(posedge clk); #1;
        iv[k] = 1'b0;
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        t = 1;
        while (!ov[k] && t < 60) begin @(posedge clk); #1; t++; end
        check("latency", t, n + 1);
        check("s", sw[k], m[15:0]);
        check("cout", co[k], m[16]);
        check("ovf", of[k], m[17]);
        check("ready_low", ir[k], 0);
        for (int i = 0; i < stall; i++) begin
            iv[k] = 1'($urandom);
            @(posedge clk); #1;
            check("hold_valid", ov[k], 1);
            check("hold_s", sw[k], m[15:0]);
            check("hold_ready", ir[k], 0);
        end
        iv[k] = 1'b0;
        ordy[k] = 1'b1;
        @(posedge clk); #1;
        check("release_valid", ov[k], 0);
        check("release_ready", ir[k], 1);
        check("keep_result", {of[k], co[k], sw[k]}, m);
    endtask

    task automatic dir(input logic [15:0] av, input logic [15:0] bv, input logic ci, input logic sb,
                       input int stall, input logic [15:0] es, input logic ec, input logic eo);
        run_op(1, av, bv, ci, sb, stall);
        check("dir_s", sw[1], es);
        check("dir_cout", co[1], ec);
        check("dir_ovf", of[1], eo);
    endtask

    initial begin
        int t, k, st, e0;
        logic [15:0] ra, rb;
        logic rc, rs;
        chk = 0; err = 0;
        rst_n = 1'b0; iv = '0; ordy = '1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check("rst_valid", ov[i], 0);
            check("rst_ready", ir[i], 1);
            check("rst_s", sw[i], 0);
            check("rst_cout", co[i], 0);
            check("rst_ovf", of[i], 0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;

        dir(16'h1234, 16'h4321, 0, 0, 0, 16'h5555, 0, 0);
        dir(16'hFFFF, 16'h0001, 0, 0, 0, 16'h0000, 1, 0);
        dir(16'h7FFF, 16'h0001, 0, 0, 0, 16'h8000, 0, 1);
        dir(16'h0005, 16'h0007, 0, 1, 0, 16'hFFFE, 0, 0);
        dir(16'h8000, 16'h0001, 0, 1, 0, 16'h7FFF, 1, 1);
        dir(16'h0010, 16'h0003, 1, 1, 0, 16'h000C, 1, 0);
        dir(16'h00F0, 16'h0F0F, 0, 0, 3, 16'h0FFF, 0, 0);

        // in_valid held high: second accept exactly N+2 edges after the first
        a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0; iv[1] = 1'b1;
        @(posedge clk); #1;
        check("accepted", ir[1], 0);
        t = 1;
        while (!ir[1] && t < 60) begin @(posedge clk); #1; t++; end
        check("issue_interval", t, 6);
        @(posedge clk); #1;
        iv[1] = 1'b0;
        check("second_accept", ir[1], 0);
        t = 0;
        while (!ov[1] && t < 60) begin @(posedge clk); #1; t++; end
        check("second_result", sw[1], 16'h3333);
        @(posedge clk); #1;
        check("second_release", ir[1], 1);

        // asynchronous reset in the second RUN cycle
        a = 16'hABCD; b = 16'h1357; iv[1] = 1'b1;
        @(posedge clk); #1;
        iv[1] = 1'b0;
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        #1;
        check("abort_valid", ov[1], 0);
        check("abort_ready", ir[1], 1);
        check("abort_s", sw[1], 0);
        check("abort_cout", co[1], 0);
        check("abort_ovf", of[1], 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("abort_no_valid", ov[1], 0);
        end
        dir(16'h0101, 16'h0202, 0, 0, 0, 16'h0303, 0, 0);

        for (int i = 0; i < 1000; i++) begin
            k = $urandom_range(0, 2);
            st = $urandom_range(0, 3);
            ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom); rs = 1'($urandom);
            e0 = err;
            run_op(k, ra, rb, rc, rs, st);
            $display("op %0d inst %0d a=%h b=%h cin=%0d sub=%0d s=%h %s", i, k, ra, rb, rc, rs, sw[k],
                     err == e0 ? "pass" : "fail");
        end

        $display("CHECKS %0d ERRORS %0d", chk, err);
        $finish;
    end
endmodule
